retention_pwr_ctrl: RTL

Always-on power/retention sequencer that drives the control side of the switchable domain built from RSDFFARX*_RVT/LVT retention flops. On a sleep request it gates the domain clock, isolates outputs, drops RETN to freeze state, and switches power off. On wake it reverses the sequence: power up, restore via RETN, release isolation, then ungate the clock. It sits in the always-on domain and is clocked by the always-on clock.

---
 rtl/pwr_ctrl_pkg.sv | 44 ++++
 rtl/pwr_dly_cnt.sv | 33 +++
 rtl/retention_pwr_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pwr_ctrl_pkg.sv
// Shared types and default timing for the retention power sequencer.
//   pwr_state_e : sequencer states
//   pwr_out_t   : registered control outputs bundled as one payload
//   DEF_*       : default delay / timeout / counter-width constants
package pwr_ctrl_pkg;

  localparam int unsigned DEF_CLK_DLY = 2;
  localparam int unsigned DEF_ISO_DLY = 2;
  localparam int unsigned DEF_RET_DLY = 4;
  localparam int unsigned DEF_PWR_TMO = 64;
  localparam int unsigned DEF_CNT_W   = 8;

  typedef enum logic [3:0] {
    ST_ON      = 4'd0,
    ST_CLK_OFF = 4'd1,
    ST_ISO_ON  = 4'd2,
    ST_SAVE    = 4'd3,
    ST_PWR_DN  = 4'd4,
    ST_OFF     = 4'd5,
    ST_PWR_UP  = 4'd6,
    ST_RESTORE = 4'd7,
    ST_ISO_OFF = 4'd8
  } pwr_state_e;

  typedef struct packed {
    logic sleep_ack;
    logic clk_en;
    logic iso_en;
    logic retn;
    logic pwr_en;
    logic pwr_err;
  } pwr_out_t;

  // Domain fully on: clock running, no isolation, retention transparent, powered.
  localparam pwr_out_t OUT_RST = '{
    sleep_ack: 1'b0,
    clk_en:    1'b1,
    iso_en:    1'b0,
    retn:      1'b1,
    pwr_en:    1'b1,
    pwr_err:   1'b0
  };

endpackage

// File: rtl/pwr_dly_cnt.sv
// Loadable down-counter with zero flag, shared by all wait/timeout states.
//   clk, rst  : always-on clock, async active-high reset
//   load      : load load_val this cycle (takes priority over decrement)
//   load_val  : value to load (delay - 1)
//   zero_c    : count is zero (combinational from the count register)
module pwr_dly_cnt
  import pwr_ctrl_pkg::*;
#(
  parameter int unsigned W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] cnt_q;

  // Saturating decrement so an idle counter parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/retention_pwr_ctrl.sv
// Always-on sleep/wake sequencer for a retention-flop power domain.
// Sleep: gate clock -> isolate -> RETN low -> power off.
// Wake : power on -> RETN high -> release isolation -> ungate clock.
//   CLK, RST   : always-on clock, async active-high reset
//   SLEEP_REQ  : 1 = sleep, 0 = wake (level)
//   PWR_ACK    : power-switch status, 1 = powered (already synchronous)
//   SLEEP_ACK  : 1 = domain fully off
//   CLK_EN     : domain clock-gate enable
//   ISO_EN     : output isolation enable
//   RETN       : retention control, 0 = hold
//   PWR_EN     : power-switch enable
//   PWR_ERR    : sticky PWR_ACK timeout flag
module retention_pwr_ctrl
  import pwr_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DLY = DEF_CLK_DLY,
  parameter int unsigned ISO_DLY = DEF_ISO_DLY,
  parameter int unsigned RET_DLY = DEF_RET_DLY,
  parameter int unsigned PWR_TMO = DEF_PWR_TMO,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic SLEEP_REQ,
  input  logic PWR_ACK,
  output logic SLEEP_ACK,
  output logic CLK_EN,
  output logic ISO_EN,
  output logic RETN,
  output logic PWR_EN,
  output logic PWR_ERR
);

  // Counter reload values: a wait of N cycles loads N-1 and exits at zero.
  localparam logic [CNT_W-1:0] CLK_LD = CNT_W'(CLK_DLY - 1);
  localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(ISO_DLY - 1);
  localparam logic [CNT_W-1:0] RET_LD = CNT_W'(RET_DLY - 1);
  localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(PWR_TMO - 1);

  pwr_state_e       state_q, state_d;
  pwr_out_t         out_q, out_d;
  logic             cnt_load_c;
  logic [CNT_W-1:0] cnt_val_c;
  logic             cnt_zero_c;

  pwr_dly_cnt #(.W(CNT_W)) u_dly_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load_c),
    .load_val (cnt_val_c),
    .zero_c   (cnt_zero_c)
  );

  // State and output registers; reset forces the domain fully on.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_ON;
      out_q   <= OUT_RST;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Next state, next outputs and counter reload. Each state's action
  // is applied on the transition into it so outputs stay registered.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    cnt_load_c = 1'b0;
    cnt_val_c  = '0;

    unique case (state_q)
      ST_ON: begin
        if (SLEEP_REQ) begin
          state_d      = ST_CLK_OFF;
          out_d.clk_en = 1'b0;
          cnt_load_c   = 1'b1;
          cnt_val_c    = CLK_LD;
        end
      end
      ST_CLK_OFF: begin
        if (cnt_zero_c) begin
          state_d      = ST_ISO_ON;
          out_d.iso_en = 1'b1;
          cnt_load_c   = 1'b1;
          cnt_val_c    = ISO_LD;
        end
      end
      ST_ISO_ON: begin
        if (cnt_zero_c) begin
          state_d    = ST_SAVE;
          out_d.retn = 1'b0;
          cnt_load_c = 1'b1;
          cnt_val_c  = RET_LD;
        end
      end
      ST_SAVE: begin
        if (cnt_zero_c) begin
          state_d      = ST_PWR_DN;
          out_d.pwr_en = 1'b0;
          cnt_load_c   = 1'b1;
          cnt_val_c    = TMO_LD;
        end
      end
      ST_PWR_DN: begin
        // Ack beats timeout when both happen on the same cycle.
        if (!PWR_ACK || cnt_zero_c) begin
          state_d         = ST_OFF;
          out_d.sleep_ack = 1'b1;
          if (PWR_ACK) begin
            out_d.pwr_err = 1'b1;
          end
        end
      end
      ST_OFF: begin
        if (!SLEEP_REQ) begin
          state_d      = ST_PWR_UP;
          out_d.pwr_en = 1'b1;
          cnt_load_c   = 1'b1;
          cnt_val_c    = TMO_LD;
        end
      end
      ST_PWR_UP: begin
        if (PWR_ACK || cnt_zero_c) begin
          state_d    = ST_RESTORE;
          out_d.retn = 1'b1;
          cnt_load_c = 1'b1;
          cnt_val_c  = ISO_LD;
          if (!PWR_ACK) begin
            out_d.pwr_err = 1'b1;
          end
        end
      end
      ST_RESTORE: begin
        if (cnt_zero_c) begin
          state_d      = ST_ISO_OFF;
          out_d.iso_en = 1'b0;
          cnt_load_c   = 1'b1;
          cnt_val_c    = CLK_LD;
        end
      end
      ST_ISO_OFF: begin
        if (cnt_zero_c) begin
          state_d         = ST_ON;
          out_d.clk_en    = 1'b1;
          out_d.sleep_ack = 1'b0;
        end
      end
      default: begin
        // Unreachable encodings recover to fully on; error history is kept.
        state_d       = ST_ON;
        out_d         = OUT_RST;
        out_d.pwr_err = out_q.pwr_err;
      end
    endcase
  end

  assign SLEEP_ACK = out_q.sleep_ack;
  assign CLK_EN    = out_q.clk_en;
  assign ISO_EN    = out_q.iso_en;
  assign RETN      = out_q.retn;
  assign PWR_EN    = out_q.pwr_en;
  assign PWR_ERR   = out_q.pwr_err;

endmodule
